// File: rtl/bpred_pkg.sv
// Shared types and constants for branch prediction resolution.
// The prediction record is sized by PC_W_DEF. A bpred_resolve instance
// whose PC_W differs from PC_W_DEF would need a matching pred_t.
package bpred_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int TAG_W_DEF   = 20;
  localparam int INSTR_BYTES = 4;

  // One fetch-time prediction carried down the pipeline.
  typedef struct packed {
    logic                taken;
    logic [PC_W_DEF-1:0] target;
  } pred_t;

endpackage

// File: rtl/bpred_stage_reg.sv
// One pipeline register for a prediction record.
// On each clock edge the first matching case applies:
//   rst    -> clear
//   flush  -> clear (flush wins over stall)
//   stall  -> hold
//   else   -> load d
module bpred_stage_reg
  import bpred_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  stall,
  input  pred_t d,
  output pred_t q
);

  // Clear on reset or flush, hold on stall, otherwise advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bpred_resolve.sv
// Execute-stage branch prediction resolution.
// Carries each BTB prediction through the D and E registers, compares it in
// E against the actual outcome, raises a redirect on mispredict, and emits
// a BTB write for every taken control transfer.
// Optional macro BPRED_PERF_EN adds saturating control-transfer and
// mispredict counters as extra outputs.
module bpred_resolve
  import bpred_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_D,
  input  logic             stall_E,
  input  logic             flush_D,
  input  logic             flush_E,
  input  logic             btb_hit_F,
  input  logic [PC_W-1:0]  btb_target_F,
  input  logic             branch_E,
  input  logic             jump_E,
  input  logic             taken_E,
  input  logic [PC_W-1:0]  pc_E,
  input  logic [PC_W-1:0]  pc_target_E,
  output logic             redirect_E,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             btb_wr_en,
  output logic [TAG_W-1:0] btb_wr_tag,
  output logic [PC_W-1:0]  btb_wr_target
`ifdef BPRED_PERF_EN
  ,
  output logic [31:0]      perf_ctrl_cnt,
  output logic [31:0]      perf_mispred_cnt
`endif
);

  pred_t pred_f;
  pred_t pred_d;
  pred_t pred_e;

  logic            actual_taken;
  logic            mis_taken;
  logic            mis_not;
  logic            resolve_ok;
  logic [PC_W-1:0] pc_seq;

  assign pred_f = '{taken: btb_hit_F, target: btb_target_F};

  bpred_stage_reg u_stage_d (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_D),
    .stall (stall_D),
    .d     (pred_f),
    .q     (pred_d)
  );

  bpred_stage_reg u_stage_e (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_E),
    .stall (stall_E),
    .d     (pred_d),
    .q     (pred_e)
  );

  // Sequential PC wraps naturally at the PC width.
  assign pc_seq = pc_E + PC_W'(INSTR_BYTES);

  // Resolve the E-stage instruction against its prediction. A stalled or
  // flushed E slot issues nothing, so each instruction resolves exactly once.
  always_comb begin
    actual_taken  = jump_E | (branch_E & taken_E);
    mis_taken     = actual_taken & (!pred_e.taken || (pred_e.target != pc_target_E));
    mis_not       = pred_e.taken & !actual_taken;
    resolve_ok    = !flush_E & !stall_E;
    redirect_E    = (mis_taken | mis_not) & resolve_ok;
    btb_wr_en     = actual_taken & resolve_ok;
    redirect_pc   = '0;
    btb_wr_tag    = '0;
    btb_wr_target = '0;
    if (redirect_E) begin
      redirect_pc = mis_taken ? pc_target_E : pc_seq;
    end
    if (btb_wr_en) begin
      btb_wr_tag    = pc_E[TAG_W-1:0];
      btb_wr_target = pc_target_E;
    end
  end

`ifdef BPRED_PERF_EN
  logic ctrl_inc;

  // A resolved not-taken branch counts as a control transfer even though
  // it writes nothing to the BTB.
  assign ctrl_inc = btb_wr_en | (branch_E & !taken_E & resolve_ok);

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ctrl_cnt    <= '0;
      perf_mispred_cnt <= '0;
    end else begin
      if (ctrl_inc && (perf_ctrl_cnt != 32'hFFFF_FFFF)) begin
        perf_ctrl_cnt <= perf_ctrl_cnt + 32'd1;
      end
      if (redirect_E && (perf_mispred_cnt != 32'hFFFF_FFFF)) begin
        perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bpred_resolve.sv
// Directed testbench for bpred_resolve (also exercises BPRED_PERF_EN when defined).
module tb_bpred_resolve;

  logic        clk;
  logic        rst;
  logic        stall_D, stall_E, flush_D, flush_E;
  logic        btb_hit_F;
  logic [31:0] btb_target_F;
  logic        branch_E, jump_E, taken_E;
  logic [31:0] pc_E, pc_target_E;
  logic        redirect_E;
  logic [31:0] redirect_pc;
  logic        btb_wr_en;
  logic [19:0] btb_wr_tag;
  logic [31:0] btb_wr_target;
`ifdef BPRED_PERF_EN
  logic [31:0] perf_ctrl_cnt, perf_mispred_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  bpred_resolve dut (
    .clk           (clk),
    .rst           (rst),
    .stall_D       (stall_D),
    .stall_E       (stall_E),
    .flush_D       (flush_D),
    .flush_E       (flush_E),
    .btb_hit_F     (btb_hit_F),
    .btb_target_F  (btb_target_F),
    .branch_E      (branch_E),
    .jump_E        (jump_E),
    .taken_E       (taken_E),
    .pc_E          (pc_E),
    .pc_target_E   (pc_target_E),
    .redirect_E    (redirect_E),
    .redirect_pc   (redirect_pc),
    .btb_wr_en     (btb_wr_en),
    .btb_wr_tag    (btb_wr_tag),
    .btb_wr_target (btb_wr_target)
`ifdef BPRED_PERF_EN
    ,
    .perf_ctrl_cnt    (perf_ctrl_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_D = 0; stall_E = 0; flush_D = 0; flush_E = 0;
    btb_hit_F = 0; btb_target_F = 0;
    branch_E = 0; jump_E = 0; taken_E = 0;
    pc_E = 0; pc_target_E = 0;
  endtask

  // Put a prediction into F, then let it reach E (two edges).
  task automatic predict(input logic hit, input logic [31:0] tgt);
    btb_hit_F = hit; btb_target_F = tgt;
    tick();
    btb_hit_F = 0; btb_target_F = 0;
    tick();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    #1;
    check("reset_redirect", {31'd0, redirect_E}, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_wr_en", {31'd0, btb_wr_en}, 32'd0);
    rst = 0;
    tick();

    // Cold miss on a taken beq.
    branch_E = 1; taken_E = 1; pc_E = 32'h100; pc_target_E = 32'h80;
    #1;
    check("cold_redirect", {31'd0, redirect_E}, 32'd1);
    check("cold_redirect_pc", redirect_pc, 32'h80);
    check("cold_wr_en", {31'd0, btb_wr_en}, 32'd1);
    check("cold_wr_tag", {12'd0, btb_wr_tag}, 32'h00100);
    check("cold_wr_target", btb_wr_target, 32'h80);
    tick();
    idle();

    // Correct hit: prediction matches, no redirect, tag refreshed.
    predict(1, 32'h80);
    branch_E = 1; taken_E = 1; pc_E = 32'h100; pc_target_E = 32'h80;
    #1;
    check("hit_redirect", {31'd0, redirect_E}, 32'd0);
    check("hit_redirect_pc", redirect_pc, 32'd0);
    check("hit_wr_en", {31'd0, btb_wr_en}, 32'd1);
    tick();
    idle();

    // Predicted taken, branch not taken.
    predict(1, 32'h240);
    branch_E = 1; taken_E = 0; pc_E = 32'h200; pc_target_E = 32'h240;
    #1;
    check("nt_redirect", {31'd0, redirect_E}, 32'd1);
    check("nt_redirect_pc", redirect_pc, 32'h204);
    check("nt_wr_en", {31'd0, btb_wr_en}, 32'd0);
    check("nt_wr_target_gated", btb_wr_target, 32'd0);
    tick();
    idle();

    // jalr with wrong predicted target.
    predict(1, 32'h300);
    jump_E = 1; pc_E = 32'h400; pc_target_E = 32'h340;
    #1;
    check("jalr_redirect", {31'd0, redirect_E}, 32'd1);
    check("jalr_redirect_pc", redirect_pc, 32'h340);
    check("jalr_wr_tag", {12'd0, btb_wr_tag}, 32'h00400);
    check("jalr_wr_target", btb_wr_target, 32'h340);
    tick();
    idle();

    // Stale hit on a non-branch at the top of the address space wraps.
    predict(1, 32'h10);
    pc_E = 32'hFFFF_FFFC; pc_target_E = 32'h10;
    #1;
    check("wrap_redirect", {31'd0, redirect_E}, 32'd1);
    check("wrap_redirect_pc", redirect_pc, 32'h0);
    check("wrap_wr_en", {31'd0, btb_wr_en}, 32'd0);
    tick();
    idle();

    // Stall E for three cycles on a mispredicted (not-taken) branch.
    predict(1, 32'h700);
    stall_E = 1; branch_E = 1; taken_E = 0; pc_E = 32'h500; pc_target_E = 32'h700;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_no_redirect", {31'd0, redirect_E}, 32'd0);
      check("stall_no_wr", {31'd0, btb_wr_en}, 32'd0);
      tick();
    end
    stall_E = 0;
    #1;
    check("stall_release_redirect", {31'd0, redirect_E}, 32'd1);
    check("stall_release_pc", redirect_pc, 32'h504);
    tick();
    idle();
    #1;
    check("stall_single_pulse", {31'd0, redirect_E}, 32'd0);

    // flush_D together with stall_D clears D.
    btb_hit_F = 1; btb_target_F = 32'h800;
    tick();
    btb_hit_F = 0; btb_target_F = 0;
    flush_D = 1; stall_D = 1;
    tick();
    flush_D = 0; stall_D = 0;
    tick();
    #1;
    check("flush_beats_stall", {31'd0, redirect_E}, 32'd0);

    // flush_E gates the current slot and leaves a non-redirecting bubble.
    predict(1, 32'h880);
    #1;
    check("pre_flush_redirect", {31'd0, redirect_E}, 32'd1);
    flush_E = 1;
    #1;
    check("flush_e_gated", {31'd0, redirect_E}, 32'd0);
    tick();
    flush_E = 0;
    #1;
    check("flush_bubble", {31'd0, redirect_E}, 32'd0);
    idle();

    // Reset while E holds a taken prediction.
    predict(1, 32'h900);
    #1;
    check("pre_rst_redirect_pc", redirect_pc, 32'h4);
    rst = 1;
    tick();
    check("rst_redirect", {31'd0, redirect_E}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_wr_en", {31'd0, btb_wr_en}, 32'd0);
    rst = 0;

`ifdef BPRED_PERF_EN
    tick();
    check("perf_ctrl_reset", perf_ctrl_cnt, 32'd0);
    // Ten branches with no prediction: 3 taken (mispredicted), 7 not taken.
    for (int i = 0; i < 10; i++) begin
      branch_E = 1; taken_E = (i % 3 == 0) && (i < 9); pc_E = 32'h1000 + i * 4; pc_target_E = 32'h2000;
      tick();
    end
    idle();
    #1;
    check("perf_ctrl_cnt", perf_ctrl_cnt, 32'd10);
    check("perf_mispred_cnt", perf_mispred_cnt, 32'd3);
    force dut.perf_ctrl_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.perf_ctrl_cnt;
    branch_E = 1; taken_E = 0; pc_E = 32'h3000;
    tick();
    idle();
    #1;
    check("perf_ctrl_saturate", perf_ctrl_cnt, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
